// File: rtl/regfile_param.sv
// Parametrised register file with an init sweep that clears one entry per cycle
// after reset, optional hardwired zero register and optional write-to-read bypass.
module regfile_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     ready,
    output logic                     wr_drop
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        INIT,
        RUN
    } stateType;

    stateType          state;
    stateType          stateNext;
    logic [ADDR_W-1:0] sweepCnt;
    logic [ADDR_W-1:0] sweepCntNext;
    logic              wrDropNext;
    logic              zeroWrite;
    logic              writeAccepted;
    logic              arrWe;
    logic [ADDR_W-1:0] arrAddr;
    logic [DATA_W-1:0] arrData;

    // The array has no reset of its own so it can map onto distributed RAM.
    logic [DATA_W-1:0] rf [DEPTH];

    assign ready         = (state == RUN);
    assign zeroWrite     = ZERO_REG && (wr_addr == '0);
    assign writeAccepted = (state == RUN) && wr_en && !zeroWrite;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= INIT;
            sweepCnt <= '0;
            wr_drop  <= 1'b0;
        end else begin
            state    <= stateNext;
            sweepCnt <= sweepCntNext;
            wr_drop  <= wrDropNext;
        end
    end

    // The sweep and normal writes share the single array write port.
    always_comb begin
        stateNext    = state;
        sweepCntNext = sweepCnt;
        wrDropNext   = 1'b0;
        arrWe        = 1'b0;
        arrAddr      = wr_addr;
        arrData      = wr_data;
        case (state)
            INIT: begin
                arrWe        = 1'b1;
                arrAddr      = sweepCnt;
                arrData      = '0;
                sweepCntNext = sweepCnt + ADDR_W'(1);
                wrDropNext   = wr_en && !zeroWrite;
                if (&sweepCnt) begin
                    stateNext = RUN;
                end
            end
            RUN: begin
                arrWe = writeAccepted;
            end
            default: begin
                stateNext = INIT;
            end
        endcase
        if (!rst_n) begin
            arrWe = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (arrWe) begin
            rf[arrAddr] <= arrData;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : gRead
        logic [ADDR_W-1:0] portAddr;
        logic [DATA_W-1:0] portData;

        assign portAddr = rd_addr[i*ADDR_W +: ADDR_W];

        always_comb begin
            portData = rf[portAddr];
            if (!ready) begin
                portData = '0;
            end else if (ZERO_REG && (portAddr == '0)) begin
                portData = '0;
            end else if (BYPASS && writeAccepted && (wr_addr == portAddr)) begin
                portData = wr_data;
            end
        end

        assign rd_data[i*DATA_W +: DATA_W] = portData;
    end

endmodule

// File: tb/tb_regfile_param.sv
// Randomised self-checking bench for regfile_param; three instances cover the
// default configuration, no-bypass/no-zero-register, and a small 4-port variant.
module tb_regfile_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: defaults (ZERO_REG=1, BYPASS=1)
    logic        rstA = 1'b0, wenA = 1'b0;
    logic [4:0]  waddrA = '0;
    logic [31:0] wdataA = '0;
    logic [9:0]  raddrA = '0;
    logic [63:0] rdataA;
    logic        readyA, dropA;

    // Instance B: ZERO_REG=0, BYPASS=0
    logic        rstB = 1'b0, wenB = 1'b0;
    logic [4:0]  waddrB = '0;
    logic [31:0] wdataB = '0;
    logic [9:0]  raddrB = '0;
    logic [63:0] rdataB;
    logic        readyB, dropB;

    // Instance C: 16-bit, 8 entries, 4 read ports
    logic        rstC = 1'b0, wenC = 1'b0;
    logic [2:0]  waddrC = '0;
    logic [15:0] wdataC = '0;
    logic [11:0] raddrC = '0;
    logic [63:0] rdataC;
    logic        readyC, dropC;

    regfile_param #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1'b1), .BYPASS(1'b1)) dutA (
        .clk(clk), .rst_n(rstA), .rd_addr(raddrA), .rd_data(rdataA), .wr_en(wenA),
        .wr_addr(waddrA), .wr_data(wdataA), .ready(readyA), .wr_drop(dropA));

    regfile_param #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1'b0), .BYPASS(1'b0)) dutB (
        .clk(clk), .rst_n(rstB), .rd_addr(raddrB), .rd_data(rdataB), .wr_en(wenB),
        .wr_addr(waddrB), .wr_data(wdataB), .ready(readyB), .wr_drop(dropB));

    regfile_param #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4), .ZERO_REG(1'b1), .BYPASS(1'b1)) dutC (
        .clk(clk), .rst_n(rstC), .rd_addr(raddrC), .rd_data(rdataC), .wr_en(wenC),
        .wr_addr(waddrC), .wr_data(wdataC), .ready(readyC), .wr_drop(dropC));

    // Reference model: ready after DEPTH clean edges, contents zero at that point.
    int          mDepth[3] = '{32, 32, 8};
    bit          mZero[3]  = '{1'b1, 1'b0, 1'b1};
    bit          mByp[3]   = '{1'b1, 1'b0, 1'b1};
    logic [31:0] mMask[3]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_FFFF};
    bit          mRdy[3]   = '{1'b0, 1'b0, 1'b0};
    bit          mDrop[3]  = '{1'b0, 1'b0, 1'b0};
    int          mCnt[3]   = '{0, 0, 0};
    logic [31:0] mMem[3][32];

    function automatic void modelStep(int id, bit rstn, bit wen, int waddr, logic [31:0] wdata);
        bit acc;
        acc = wen && !(mZero[id] && waddr == 0);
        if (!rstn) begin
            mRdy[id]  = 1'b0;
            mCnt[id]  = 0;
            mDrop[id] = 1'b0;
        end else if (!mRdy[id]) begin
            mDrop[id] = acc;
            mCnt[id]++;
            if (mCnt[id] == mDepth[id]) begin
                mRdy[id] = 1'b1;
                for (int i = 0; i < 32; i++) mMem[id][i] = '0;
            end
        end else begin
            mDrop[id] = 1'b0;
            if (acc) mMem[id][waddr] = wdata & mMask[id];
        end
    endfunction

    function automatic logic [31:0] expRead(int id, int raddr, bit wen, int waddr, logic [31:0] wdata);
        if (!mRdy[id]) return '0;
        if (mZero[id] && raddr == 0) return '0;
        if (mByp[id] && wen && !(mZero[id] && waddr == 0) && waddr == raddr) return wdata & mMask[id];
        return mMem[id][raddr];
    endfunction

    task automatic tick();
        modelStep(0, rstA, wenA, int'(waddrA), wdataA);
        modelStep(1, rstB, wenB, int'(waddrB), wdataB);
        modelStep(2, rstC, wenC, int'(waddrC), {16'h0, wdataC});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic expR;
        tick();
        tick();
        checks++; if (readyA !== 1'b0) begin errors++; $display("[TB] FAIL reset_readyA: got %b expected 0", readyA); end
        checks++; if (dropA !== 1'b0) begin errors++; $display("[TB] FAIL reset_dropA: got %b expected 0", dropA); end
        checks++; if (readyB !== 1'b0) begin errors++; $display("[TB] FAIL reset_readyB: got %b expected 0", readyB); end
        checks++; if (readyC !== 1'b0) begin errors++; $display("[TB] FAIL reset_readyC: got %b expected 0", readyC); end
        checks++; if (dropC !== 1'b0) begin errors++; $display("[TB] FAIL reset_dropC: got %b expected 0", dropC); end
        rstA = 1'b1; rstB = 1'b1; rstC = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            tick();
            expR = (k >= 32);
            checks++; if (readyA !== expR) begin errors++; $display("[TB] FAIL sweep_readyA edge %0d: got %b expected %b", k, readyA, expR); end
            checks++; if (readyB !== expR) begin errors++; $display("[TB] FAIL sweep_readyB edge %0d: got %b expected %b", k, readyB, expR); end
            expR = (k >= 8);
            checks++; if (readyC !== expR) begin errors++; $display("[TB] FAIL sweep_readyC edge %0d: got %b expected %b", k, readyC, expR); end
            if (k < 32) begin
                raddrA = 10'($urandom);
                #2;
                checks++; if (rdataA !== 64'h0) begin errors++; $display("[TB] FAIL sweep_rdataA edge %0d: got %h expected 0", k, rdataA); end
            end
        end
        for (int a = 0; a < 32; a++) begin
            raddrA = {2{5'(a)}};
            raddrB = {2{5'(a)}};
            #1;
            checks++; if (rdataA !== 64'h0) begin errors++; $display("[TB] FAIL cleared_A x%0d: got %h expected 0", a, rdataA); end
            checks++; if (rdataB !== 64'h0) begin errors++; $display("[TB] FAIL cleared_B x%0d: got %h expected 0", a, rdataB); end
        end
        for (int a = 0; a < 8; a++) begin
            raddrC = {4{3'(a)}};
            #1;
            checks++; if (rdataC !== 64'h0) begin errors++; $display("[TB] FAIL cleared_C x%0d: got %h expected 0", a, rdataC); end
        end
    endtask

    task automatic test_basic();
        wenB = 1'b1; waddrB = 5'd5; wdataB = 32'hDEAD_BEEF; raddrB = {5'd5, 5'd5};
        #2;
        checks++; if (rdataB !== 64'h0) begin errors++; $display("[TB] FAIL basic_same_cycle: got %h expected 0", rdataB); end
        tick();
        wenB = 1'b0;
        #2;
        checks++; if (rdataB !== {2{32'hDEAD_BEEF}}) begin errors++; $display("[TB] FAIL basic_next_cycle: got %h expected %h", rdataB, {2{32'hDEAD_BEEF}}); end
    endtask

    task automatic test_bypass();
        wenA = 1'b1; waddrA = 5'd7; wdataA = 32'h1234_5678; raddrA = {5'd7, 5'd7};
        #2;
        checks++; if (rdataA !== {2{32'h1234_5678}}) begin errors++; $display("[TB] FAIL bypass_same_cycle: got %h expected %h", rdataA, {2{32'h1234_5678}}); end
        tick();
        wenA = 1'b0;
        #2;
        checks++; if (rdataA !== {2{32'h1234_5678}}) begin errors++; $display("[TB] FAIL bypass_stored: got %h expected %h", rdataA, {2{32'h1234_5678}}); end
    endtask

    task automatic test_zero();
        wenA = 1'b1; waddrA = 5'd0; wdataA = 32'hFFFF_FFFF; raddrA = {5'd0, 5'd0};
        #2;
        checks++; if (rdataA !== 64'h0) begin errors++; $display("[TB] FAIL zero_same_cycle: got %h expected 0", rdataA); end
        tick();
        wenA = 1'b0;
        #2;
        checks++; if (rdataA !== 64'h0) begin errors++; $display("[TB] FAIL zero_after: got %h expected 0", rdataA); end
        checks++; if (dropA !== 1'b0) begin errors++; $display("[TB] FAIL zero_drop: got %b expected 0", dropA); end
        wenB = 1'b1; waddrB = 5'd0; wdataB = 32'hFFFF_FFFF;
        tick();
        wenB = 1'b0; raddrB = {5'd0, 5'd0};
        #2;
        checks++; if (rdataB !== {2{32'hFFFF_FFFF}}) begin errors++; $display("[TB] FAIL nozero_x0: got %h expected %h", rdataB, {2{32'hFFFF_FFFF}}); end
    endtask

    task automatic test_random();
        logic [31:0] e;
        for (int n = 0; n < 300; n++) begin
            wenA = 1'($urandom); waddrA = 5'($urandom); wdataA = $urandom; raddrA = 10'($urandom);
            wenB = 1'($urandom); waddrB = 5'($urandom); wdataB = $urandom; raddrB = 10'($urandom);
            wenC = 1'($urandom); waddrC = 3'($urandom); wdataC = 16'($urandom); raddrC = 12'($urandom);
            if ($urandom_range(0, 2) == 0) raddrA[4:0] = waddrA;
            if ($urandom_range(0, 2) == 0) raddrB[9:5] = waddrB;
            if ($urandom_range(0, 2) == 0) raddrC[8:6] = waddrC;
            #2;
            for (int p = 0; p < 2; p++) begin
                e = expRead(0, int'(raddrA[p*5 +: 5]), wenA, int'(waddrA), wdataA);
                checks++; if (rdataA[p*32 +: 32] !== e) begin errors++; $display("[TB] FAIL rand_A port %0d: got %h expected %h", p, rdataA[p*32 +: 32], e); end
                e = expRead(1, int'(raddrB[p*5 +: 5]), wenB, int'(waddrB), wdataB);
                checks++; if (rdataB[p*32 +: 32] !== e) begin errors++; $display("[TB] FAIL rand_B port %0d: got %h expected %h", p, rdataB[p*32 +: 32], e); end
            end
            for (int p = 0; p < 4; p++) begin
                e = expRead(2, int'(raddrC[p*3 +: 3]), wenC, int'(waddrC), {16'h0, wdataC});
                checks++; if (rdataC[p*16 +: 16] !== e[15:0]) begin errors++; $display("[TB] FAIL rand_C port %0d: got %h expected %h", p, rdataC[p*16 +: 16], e[15:0]); end
            end
            checks++; if (dropA !== mDrop[0] || dropB !== mDrop[1] || dropC !== mDrop[2]) begin
                errors++; $display("[TB] FAIL rand_drop: got %b%b%b expected %b%b%b", dropA, dropB, dropC, mDrop[0], mDrop[1], mDrop[2]);
            end
            tick();
        end
        wenA = 1'b0; wenB = 1'b0; wenC = 1'b0;
    endtask

    task automatic test_midrun_reset();
        int n;
        wenA = 1'b1;
        for (int a = 1; a < 32; a++) begin
            waddrA = 5'(a); wdataA = 32'(a);
            tick();
        end
        wenA = 1'b0; raddrA = {5'd31, 5'd17};
        #2;
        checks++; if (rdataA !== {32'd31, 32'd17}) begin errors++; $display("[TB] FAIL fill_A: got %h expected %h", rdataA, {32'd31, 32'd17}); end
        rstA = 1'b0; wenA = 1'b1; waddrA = 5'd4; wdataA = 32'hCAFE;
        tick();
        checks++; if (readyA !== 1'b0) begin errors++; $display("[TB] FAIL midrst_ready: got %b expected 0", readyA); end
        checks++; if (dropA !== 1'b0) begin errors++; $display("[TB] FAIL midrst_drop: got %b expected 0", dropA); end
        rstA = 1'b1; wenA = 1'b0;
        n = 0;
        while (readyA !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checks++; if (n != 32) begin errors++; $display("[TB] FAIL midrst_latency: got %0d edges expected 32", n); end
        for (int a = 0; a < 32; a++) begin
            raddrA = {2{5'(a)}};
            #1;
            checks++; if (rdataA !== 64'h0) begin errors++; $display("[TB] FAIL midrst_clear x%0d: got %h expected 0", a, rdataA); end
        end
    endtask

    task automatic test_init_reject();
        logic expD, expR;
        rstA = 1'b0;
        tick();
        rstA = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            wenA = (k == 10 || k == 32);
            waddrA = (k == 10) ? 5'd3 : 5'd9;
            wdataA = 32'hA5A5_A5A5;
            tick();
            wenA = 1'b0;
            expD = (k == 10 || k == 32);
            expR = (k >= 32);
            checks++; if (dropA !== expD) begin errors++; $display("[TB] FAIL reject_drop edge %0d: got %b expected %b", k, dropA, expD); end
            checks++; if (readyA !== expR) begin errors++; $display("[TB] FAIL reject_ready edge %0d: got %b expected %b", k, readyA, expR); end
        end
        tick();
        checks++; if (dropA !== 1'b0) begin errors++; $display("[TB] FAIL reject_drop_end: got %b expected 0", dropA); end
        raddrA = {5'd9, 5'd3};
        #2;
        checks++; if (rdataA !== 64'h0) begin errors++; $display("[TB] FAIL reject_content: got %h expected 0", rdataA); end
    endtask

    task automatic test_small_config();
        int n, s;
        logic [2:0]  addrs[4];
        logic [15:0] vals[4];
        wenC = 1'b1;
        for (int a = 1; a < 8; a++) begin
            waddrC = 3'(a); wdataC = 16'(a + 100);
            tick();
        end
        rstC = 1'b0; wenC = 1'b0;
        tick();
        rstC = 1'b1;
        n = 0;
        while (readyC !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        checks++; if (n != 8) begin errors++; $display("[TB] FAIL small_latency: got %0d edges expected 8", n); end
        for (int a = 0; a < 8; a++) begin
            raddrC = {4{3'(a)}};
            #1;
            checks++; if (rdataC !== 64'h0) begin errors++; $display("[TB] FAIL small_clear x%0d: got %h expected 0", a, rdataC); end
        end
        s = $urandom_range(0, 6);
        for (int j = 0; j < 4; j++) begin
            addrs[j] = 3'(((s + 2 * j) % 7) + 1);
            vals[j]  = 16'($urandom);
            wenC = 1'b1; waddrC = addrs[j]; wdataC = vals[j];
            tick();
        end
        wenC = 1'b0;
        raddrC = {addrs[3], addrs[2], addrs[1], addrs[0]};
        #2;
        for (int j = 0; j < 4; j++) begin
            checks++; if (rdataC[j*16 +: 16] !== vals[j]) begin errors++; $display("[TB] FAIL small_read port %0d x%0d: got %h expected %h", j, addrs[j], rdataC[j*16 +: 16], vals[j]); end
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete within the time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_bypass();
        test_zero();
        test_random();
        test_midrun_reset();
        test_init_reject();
        test_small_config();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised register file for the multicycle RISC-V core. It generalises the 32x32, two-read-port register file in three ways: configurable width, depth and read-port count; an optional hardwired zero register; and optional write-to-read bypass. It adds a synchronous active-low reset that runs a sweep FSM, clearing every entry one per cycle so the array still infers as FPGA distributed RAM. It sits between the decode/writeback stages and the ALU operand registers.

## Interface
Parameters:
- DATA_W, 32, width of each register in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- NUM_RD, 2, number of independent combinational read ports (1..8)
- ZERO_REG, 1, when 1, entry 0 always reads 0 and ignores writes
- BYPASS, 1, when 1, a same-cycle accepted write is forwarded to matching read ports

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i is bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  packed read data; port i is bits [i*DATA_W +: DATA_W]; combinational
- wr_en  in  1  write request
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- ready  out  1  high when the init sweep is complete and writes are accepted
- wr_drop  out  1  registered one-cycle pulse; a write request was rejected during the sweep

## Operation
- FSM states: INIT (sweep) and RUN. A sweep counter sweep_cnt is ADDR_W bits wide.
- rst_n low at an edge: state becomes INIT, sweep_cnt becomes 0, ready becomes 0 and wr_drop becomes 0. Array contents are not touched on that edge.
- INIT, each edge with rst_n high:
  - writes 0 to RF[sweep_cnt], then increments sweep_cnt;
  - on the edge that writes entry DEPTH-1, state becomes RUN and ready becomes 1;
  - sweep_cnt wraps to 0 and stays there in RUN.
- RUN: an accepted write is wr_en=1 and not (ZERO_REG=1 and wr_addr=0). It stores wr_data into RF[wr_addr] on the edge.
- Write rejection in INIT: wr_en=1 is ignored. wr_drop=1 on the following cycle only.
- wr_en to address 0 with ZERO_REG=1 is a silent no-op: no store and no wr_drop.
- Read port i, evaluated in priority order:
  1. ready=0: return 0.
  2. ZERO_REG=1 and rd_addr_i=0: return 0.
  3. BYPASS=1, accepted write this cycle and wr_addr=rd_addr_i: return wr_data.
  4. Otherwise return RF[rd_addr_i].
- Ports are independent. Any number of ports may read the same address.

## Timing
- Reset values: ready=0, wr_drop=0, state INIT, sweep_cnt=0. rd_data reads 0 throughout INIT.
- Init latency: ready rises exactly DEPTH edges after the first edge with rst_n high (32 edges for the defaults).
- Read latency is 0 cycles (combinational from rd_addr, state and write-port inputs).
- Write latency is 1 edge. With BYPASS=0, the new value is visible on the cycle after the edge.
- Reset asserted mid-sweep or in RUN: the sweep restarts from entry 0 and all prior contents are cleared again.
- A write presented on the same edge as rst_n low is discarded and does not raise wr_drop.
- A write on the edge where ready rises is still in INIT. It is rejected and wr_drop pulses.

## Test plan
- Reset sweep: hold rst_n=0 for 2 edges, release.
  - ready must stay 0 for 31 edges and go 1 on the 32nd.
  - All 32 entries then read 0 on both ports.
- Basic write/read, BYPASS=0: write 0xDEADBEEF to x5. Read x5 on both ports the next cycle and get 0xDEADBEEF; a same-cycle read gets the old value 0.
- Bypass, BYPASS=1: write 0x12345678 to x7 while rd_addr0=7 and rd_addr1=7. Both ports show 0x12345678 in the same cycle.
- Zero register: write 0xFFFFFFFF to x0. x0 reads 0 and wr_drop stays 0. With ZERO_REG=0, x0 reads 0xFFFFFFFF after the edge.
- Init rejection: assert wr_en to x3 with data 0xA5A5A5A5 during sweep cycle 10.
  - wr_drop pulses on the next cycle for exactly one cycle.
  - After ready, x3 reads 0.
- Mid-run reset and parameters: fill x1..x31 with their index, pulse rst_n low for 1 edge.
  - ready drops and rises 32 edges later, and every entry then reads 0.
  - Repeat with NUM_RD=4, ADDR_W=3, DATA_W=16: ready rises after 8 edges, and four simultaneous reads of distinct addresses return the correct values.
